// File: rtl/cpu_state_executor_pkg.sv
// Shared definitions for the micro-state executor.
//  - STATE_* micro-state codes driven by the sequencer.
//  - OP_* opcode values that the executor inspects.
//  - CW_* control-word bit positions, reused by the datapath top.
//  - decode_state(): maps state/opcode/zero flag to a control word and a decode kind.
package cpu_state_executor_pkg;

  localparam int STATE_W = 4;
  localparam int OP_W    = 8;

  typedef enum logic [STATE_W-1:0] {
    STATE_FETCH_PC   = 4'h0,
    STATE_FETCH_INST = 4'h1,
    STATE_LOAD_ADDR  = 4'h2,
    STATE_LDI        = 4'h3,
    STATE_RAM_A      = 4'h4,
    STATE_RAM_B      = 4'h5,
    STATE_STORE_A    = 4'h6,
    STATE_ALU_OP     = 4'h7,
    STATE_OUT_A      = 4'h8,
    STATE_JUMP       = 4'h9,
    STATE_HALT       = 4'hA,
    STATE_NEXT       = 4'hB
  } state_code_t;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 8'h00,
    OP_LDA = 8'h01,
    OP_ADD = 8'h02,
    OP_SUB = 8'h03,
    OP_STA = 8'h04,
    OP_LDI = 8'h05,
    OP_JMP = 8'h06,
    OP_JEZ = 8'h07,
    OP_JNZ = 8'h08,
    OP_OUT = 8'h0E,
    OP_HLT = 8'h0F
  } opcode_t;

  // Control-word bit positions
  localparam int CW_PC_INC   = 0;
  localparam int CW_PC_LOAD  = 1;
  localparam int CW_MAR_LOAD = 2;
  localparam int CW_RAM_RD   = 3;
  localparam int CW_RAM_WR   = 4;
  localparam int CW_IR_LOAD  = 5;
  localparam int CW_A_LOAD   = 6;
  localparam int CW_B_LOAD   = 7;
  localparam int CW_ALU_SUB  = 8;
  localparam int CW_ALU_EN   = 9;
  localparam int CW_OUT_LOAD = 10;
  localparam int CW_W        = 11;

  typedef logic [CW_W-1:0] ctrl_word_t;

  typedef enum logic [1:0] {
    DEC_STROBE  = 2'd0,
    DEC_NEXT    = 2'd1,
    DEC_HALT    = 2'd2,
    DEC_ILLEGAL = 2'd3
  } dec_kind_t;

  typedef struct packed {
    dec_kind_t  kind;
    ctrl_word_t cw;
  } decode_t;

  function automatic decode_t decode_state(input logic [STATE_W-1:0] state,
                                           input logic [OP_W-1:0]    opcode,
                                           input logic               zero_flag);
    decode_t d;
    logic    taken;
    d.kind = DEC_STROBE;
    d.cw   = '0;
    taken  = (opcode == OP_JMP) ||
             ((opcode == OP_JEZ) && zero_flag) ||
             ((opcode == OP_JNZ) && !zero_flag);
    case (state)
      STATE_FETCH_PC:   d.cw[CW_MAR_LOAD] = 1'b1;
      STATE_FETCH_INST: begin
        d.cw[CW_RAM_RD]  = 1'b1;
        d.cw[CW_IR_LOAD] = 1'b1;
        d.cw[CW_PC_INC]  = 1'b1;
      end
      STATE_LOAD_ADDR: begin
        d.cw[CW_RAM_RD]   = 1'b1;
        d.cw[CW_MAR_LOAD] = 1'b1;
        d.cw[CW_PC_INC]   = 1'b1;
      end
      STATE_LDI: begin
        d.cw[CW_RAM_RD] = 1'b1;
        d.cw[CW_A_LOAD] = 1'b1;
        d.cw[CW_PC_INC] = 1'b1;
      end
      STATE_RAM_A: begin
        d.cw[CW_RAM_RD] = 1'b1;
        d.cw[CW_A_LOAD] = 1'b1;
      end
      STATE_RAM_B: begin
        d.cw[CW_RAM_RD] = 1'b1;
        d.cw[CW_B_LOAD] = 1'b1;
      end
      STATE_STORE_A:    d.cw[CW_RAM_WR] = 1'b1;
      STATE_ALU_OP: begin
        d.cw[CW_ALU_EN]  = 1'b1;
        d.cw[CW_A_LOAD]  = 1'b1;
        d.cw[CW_ALU_SUB] = (opcode == OP_SUB);
      end
      STATE_OUT_A:      d.cw[CW_OUT_LOAD] = 1'b1;
      STATE_JUMP: begin
        // Not taken still has to step over the operand byte.
        if (taken) begin
          d.cw[CW_RAM_RD]  = 1'b1;
          d.cw[CW_PC_LOAD] = 1'b1;
        end else begin
          d.cw[CW_PC_INC] = 1'b1;
        end
      end
      STATE_HALT:       d.kind = DEC_HALT;
      STATE_NEXT:       d.kind = DEC_NEXT;
      default:          d.kind = DEC_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_state_executor_if.sv
// Sequencer <-> executor bundle.
//  master: sequencer/datapath side, drives state, opcode, alu_zero; receives strobes,
//          flags and reset_cycle.
//  slave:  executor side.
interface cpu_state_executor_if
  import cpu_state_executor_pkg::*;
#(
  parameter int STATE_BITS = STATE_W,
  parameter int OP_BITS    = OP_W
) ();
  logic [STATE_BITS-1:0] state;
  logic [OP_BITS-1:0]    opcode;
  logic                  alu_zero;
  logic pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load;
  logic a_load, b_load, alu_sub, alu_en, out_load;
  logic zero_flag, halted, reset_cycle, illegal;

  modport master (
    output state, opcode, alu_zero,
    input  pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load,
    input  a_load, b_load, alu_sub, alu_en, out_load,
    input  zero_flag, halted, reset_cycle, illegal
  );

  modport slave (
    input  state, opcode, alu_zero,
    output pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load,
    output a_load, b_load, alu_sub, alu_en, out_load,
    output zero_flag, halted, reset_cycle, illegal
  );
endinterface

// File: rtl/cpu_step_watchdog.sv
// Step watchdog: counts micro-steps since the last STATE_NEXT.
//  clk, reset : clock, async active-high reset
//  step       : a non-NEXT step happened this cycle
//  clear      : STATE_NEXT seen, restart the count
//  freeze     : hold count, suppress expiry (CPU halted / halting)
//  expire     : combinational, high in the step that reaches MAX_STEPS-1
module cpu_step_watchdog #(
  parameter int MAX_STEPS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic clear,
  input  logic freeze,
  output logic expire
);
  localparam int CNT_W = (MAX_STEPS > 2) ? $clog2(MAX_STEPS) : 1;

  logic [CNT_W-1:0] count_reg;

  assign expire = step && !freeze && (count_reg == CNT_W'(MAX_STEPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (!freeze) begin
      if (clear || expire)
        count_reg <= '0;
      else if (step)
        count_reg <= count_reg + CNT_W'(1);
    end
  end
endmodule

// File: rtl/cpu_state_executor.sv
// Micro-state executor: decodes the sequencer state into registered datapath strobes,
// owns the zero flag, the sticky halt latch and the step watchdog.
//  clk, reset : clock, async active-high reset
//  bus        : cpu_state_executor_if.slave (state/opcode/alu_zero in; strobes,
//               zero_flag, halted, reset_cycle, illegal out)
// Optional: define CTRL_ILLEGAL_TRAP_EN to make undefined state codes set the sticky
// illegal flag and halt; otherwise they yield an all-zero strobe cycle.
module cpu_state_executor
  import cpu_state_executor_pkg::*;
#(
  parameter int MAX_STEPS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  cpu_state_executor_if.slave    bus
);
  ctrl_word_t cw_reg;
  logic       zero_flag_reg;
  logic       halted_reg;
  logic       reset_cycle_reg;
  decode_t    dec;
  logic       trap;
  logic       halt_req;
  logic       is_next;
  logic       expire;

  assign dec      = decode_state(bus.state, bus.opcode, zero_flag_reg);
  assign is_next  = (dec.kind == DEC_NEXT);
  assign halt_req = (dec.kind == DEC_HALT) || trap;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_reg;
  assign trap = (dec.kind == DEC_ILLEGAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      illegal_reg <= 1'b0;
    else if (trap && !halted_reg)
      illegal_reg <= 1'b1;
  end
  assign bus.illegal = illegal_reg;
`else
  assign trap        = 1'b0;
  assign bus.illegal = 1'b0;
`endif

  // Freezing on halt_req as well makes a halt win over a same-cycle expiry.
  cpu_step_watchdog #(.MAX_STEPS(MAX_STEPS)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .step   (!is_next),
    .clear  (is_next),
    .freeze (halted_reg || halt_req),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cw_reg          <= '0;
      zero_flag_reg   <= 1'b0;
      halted_reg      <= 1'b0;
      reset_cycle_reg <= 1'b0;
    end else if (halted_reg) begin
      cw_reg          <= '0;
      reset_cycle_reg <= 1'b0;
    end else begin
      halted_reg      <= halt_req;
      cw_reg          <= halt_req ? '0 : dec.cw;
      reset_cycle_reg <= !halt_req && (is_next || expire);
      if (bus.state == STATE_ALU_OP)
        zero_flag_reg <= bus.alu_zero;
    end
  end

  assign bus.pc_inc      = cw_reg[CW_PC_INC];
  assign bus.pc_load     = cw_reg[CW_PC_LOAD];
  assign bus.mar_load    = cw_reg[CW_MAR_LOAD];
  assign bus.ram_rd      = cw_reg[CW_RAM_RD];
  assign bus.ram_wr      = cw_reg[CW_RAM_WR];
  assign bus.ir_load     = cw_reg[CW_IR_LOAD];
  assign bus.a_load      = cw_reg[CW_A_LOAD];
  assign bus.b_load      = cw_reg[CW_B_LOAD];
  assign bus.alu_sub     = cw_reg[CW_ALU_SUB];
  assign bus.alu_en      = cw_reg[CW_ALU_EN];
  assign bus.out_load    = cw_reg[CW_OUT_LOAD];
  assign bus.zero_flag   = zero_flag_reg;
  assign bus.halted      = halted_reg;
  assign bus.reset_cycle = reset_cycle_reg;
endmodule

// File: tb/tb_cpu_state_executor.sv
// Directed bench for cpu_state_executor. Strobes are compared as an 11-bit word
// {pc_inc,pc_load,mar_load,ram_rd,ram_wr,ir_load,a_load,b_load,alu_sub,alu_en,out_load}.
module tb_cpu_state_executor;
  import cpu_state_executor_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  cpu_state_executor_if bus ();

  cpu_state_executor #(.MAX_STEPS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed strobe words
  localparam logic [10:0] W_NONE       = 11'b000_0000_0000;
  localparam logic [10:0] W_FETCH_PC   = 11'b001_0000_0000;
  localparam logic [10:0] W_FETCH_INST = 11'b100_1010_0000;
  localparam logic [10:0] W_LOAD_ADDR  = 11'b101_1000_0000;
  localparam logic [10:0] W_LDI        = 11'b100_1001_0000;
  localparam logic [10:0] W_RAM_A      = 11'b000_1001_0000;
  localparam logic [10:0] W_RAM_B      = 11'b000_1000_1000;
  localparam logic [10:0] W_STORE_A    = 11'b000_0100_0000;
  localparam logic [10:0] W_ALU_ADD    = 11'b000_0001_0010;
  localparam logic [10:0] W_ALU_SUB    = 11'b000_0001_0110;
  localparam logic [10:0] W_OUT_A      = 11'b000_0000_0001;
  localparam logic [10:0] W_JMP_TAKEN  = 11'b010_1000_0000;
  localparam logic [10:0] W_JMP_SKIP   = 11'b100_0000_0000;

  function automatic logic [10:0] strobes();
    return {bus.pc_inc, bus.pc_load, bus.mar_load, bus.ram_rd, bus.ram_wr, bus.ir_load,
            bus.a_load, bus.b_load, bus.alu_sub, bus.alu_en, bus.out_load};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] st, input logic [7:0] op, input logic az);
    bus.state    = st;
    bus.opcode   = op;
    bus.alu_zero = az;
  endtask

  task automatic test_reset();
    checks++;
    if (strobes() !== W_NONE || bus.reset_cycle !== 1'b0 || bus.halted !== 1'b0 ||
        bus.zero_flag !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: strobes=%b rc=%b h=%b z=%b il=%b expected all 0",
               strobes(), bus.reset_cycle, bus.halted, bus.zero_flag, bus.illegal);
    end
    $display("reset_state: strobes=%b", strobes());
    @(negedge clk);
    reset = 1'b0;
    drive(STATE_ALU_OP, OP_ADD, 1'b1);
    tick();
    checks++;
    if (bus.zero_flag !== 1'b1) begin
      errors++;
      $display("FAIL zero_set: zero_flag=%b expected 1", bus.zero_flag);
    end
    drive(STATE_FETCH_INST, OP_NOP, 1'b0);
    tick();
    checks++;
    if (strobes() !== W_FETCH_INST) begin
      errors++;
      $display("FAIL pre_reset_fetch: strobes=%b expected %b", strobes(), W_FETCH_INST);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (strobes() !== W_NONE || bus.zero_flag !== 1'b0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: strobes=%b z=%b h=%b expected 0", strobes(), bus.zero_flag, bus.halted);
    end
    $display("async_reset mid FETCH_INST: strobes=%b z=%b", strobes(), bus.zero_flag);
    #3 reset = 1'b0;
    tick();
    checks++;
    if (bus.zero_flag !== 1'b0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL post_release: z=%b h=%b expected 0 0", bus.zero_flag, bus.halted);
    end
  endtask

  task automatic test_fetch();
    drive(STATE_NEXT, OP_NOP, 1'b0);
    tick();
    checks++;
    if (bus.reset_cycle !== 1'b1 || strobes() !== W_NONE) begin
      errors++;
      $display("FAIL fetch_next: rc=%b strobes=%b expected 1 %b", bus.reset_cycle, strobes(), W_NONE);
    end
    drive(STATE_FETCH_PC, OP_NOP, 1'b0);
    tick();
    checks++;
    if (strobes() !== W_FETCH_PC || bus.reset_cycle !== 1'b0) begin
      errors++;
      $display("FAIL fetch_pc: strobes=%b rc=%b expected %b 0", strobes(), bus.reset_cycle, W_FETCH_PC);
    end
    $display("fetch_pc: strobes=%b", strobes());
    drive(STATE_FETCH_INST, OP_NOP, 1'b0);
    tick();
    checks++;
    if (strobes() !== W_FETCH_INST) begin
      errors++;
      $display("FAIL fetch_inst: strobes=%b expected %b", strobes(), W_FETCH_INST);
    end
    $display("fetch_inst: strobes=%b", strobes());
  endtask

  task automatic test_decode_table();
    logic [3:0]  st_tab [7] = '{STATE_LOAD_ADDR, STATE_LDI, STATE_RAM_A, STATE_RAM_B,
                                STATE_STORE_A, STATE_ALU_OP, STATE_OUT_A};
    logic [10:0] exp_tab [7] = '{W_LOAD_ADDR, W_LDI, W_RAM_A, W_RAM_B,
                                 W_STORE_A, W_ALU_ADD, W_OUT_A};
    drive(STATE_NEXT, OP_NOP, 1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(st_tab[i], OP_ADD, 1'b0);
      tick();
      checks++;
      if (strobes() !== exp_tab[i] || bus.reset_cycle !== 1'b0) begin
        errors++;
        $display("FAIL decode_%0d: state=%h strobes=%b rc=%b expected %b 0",
                 i, st_tab[i], strobes(), bus.reset_cycle, exp_tab[i]);
      end
      $display("decode state=%h: strobes=%b", st_tab[i], strobes());
    end
  endtask

  task automatic test_alu_jump();
    drive(STATE_NEXT, OP_NOP, 1'b0);
    tick();
    drive(STATE_ALU_OP, OP_SUB, 1'b1);
    tick();
    checks++;
    if (strobes() !== W_ALU_SUB || bus.zero_flag !== 1'b1) begin
      errors++;
      $display("FAIL alu_sub: strobes=%b z=%b expected %b 1", strobes(), bus.zero_flag, W_ALU_SUB);
    end
    $display("alu_sub: strobes=%b z=%b", strobes(), bus.zero_flag);
    drive(STATE_JUMP, OP_JEZ, 1'b0);
    tick();
    checks++;
    if (strobes() !== W_JMP_TAKEN || bus.zero_flag !== 1'b1) begin
      errors++;
      $display("FAIL jez_taken: strobes=%b z=%b expected %b 1", strobes(), bus.zero_flag, W_JMP_TAKEN);
    end
    $display("jez z=1: strobes=%b", strobes());
    drive(STATE_ALU_OP, OP_ADD, 1'b0);
    tick();
    drive(STATE_JUMP, OP_JEZ, 1'b1);
    tick();
    checks++;
    if (strobes() !== W_JMP_SKIP || bus.zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL jez_skip: strobes=%b z=%b expected %b 0", strobes(), bus.zero_flag, W_JMP_SKIP);
    end
    $display("jez z=0: strobes=%b", strobes());
    drive(STATE_JUMP, OP_JMP, 1'b0);
    tick();
    checks++;
    if (strobes() !== W_JMP_TAKEN) begin
      errors++;
      $display("FAIL jmp: strobes=%b expected %b", strobes(), W_JMP_TAKEN);
    end
  endtask

  task automatic test_jnz_next();
    drive(STATE_NEXT, OP_NOP, 1'b0);
    tick();
    drive(STATE_ALU_OP, OP_SUB, 1'b1);
    tick();
    drive(STATE_JUMP, OP_JNZ, 1'b0);
    tick();
    checks++;
    if (strobes() !== W_JMP_SKIP) begin
      errors++;
      $display("FAIL jnz_skip: strobes=%b expected %b", strobes(), W_JMP_SKIP);
    end
    $display("jnz z=1: strobes=%b", strobes());
    drive(STATE_NEXT, OP_NOP, 1'b0);
    tick();
    checks++;
    if (bus.reset_cycle !== 1'b1 || strobes() !== W_NONE) begin
      errors++;
      $display("FAIL next_pulse: rc=%b strobes=%b expected 1 %b", bus.reset_cycle, strobes(), W_NONE);
    end
    drive(STATE_FETCH_PC, OP_NOP, 1'b0);
    tick();
    checks++;
    if (bus.reset_cycle !== 1'b0) begin
      errors++;
      $display("FAIL next_one_cycle: rc=%b expected 0", bus.reset_cycle);
    end
    $display("next pulse then fetch: rc=%b", bus.reset_cycle);
  endtask

  task automatic test_watchdog();
    logic exp_rc;
    drive(STATE_NEXT, OP_NOP, 1'b0);
    tick();
    drive(STATE_FETCH_PC, OP_NOP, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_rc = (i == 8) || (i == 16);
      checks++;
      if (bus.reset_cycle !== exp_rc || strobes() !== W_FETCH_PC) begin
        errors++;
        $display("FAIL watchdog_step%0d: rc=%b strobes=%b expected %b %b",
                 i, bus.reset_cycle, strobes(), exp_rc, W_FETCH_PC);
      end
      $display("watchdog step %0d: rc=%b", i, bus.reset_cycle);
    end
  endtask

  task automatic test_halt();
    drive(STATE_NEXT, OP_NOP, 1'b0);
    tick();
    drive(STATE_FETCH_PC, OP_NOP, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    // eighth step would expire the watchdog; HALT must win
    drive(STATE_HALT, OP_HLT, 1'b0);
    tick();
    checks++;
    if (bus.halted !== 1'b1 || bus.reset_cycle !== 1'b0 || strobes() !== W_NONE) begin
      errors++;
      $display("FAIL halt_vs_wdog: h=%b rc=%b strobes=%b expected 1 0 %b",
               bus.halted, bus.reset_cycle, strobes(), W_NONE);
    end
    $display("halt at expiry: h=%b rc=%b", bus.halted, bus.reset_cycle);
    drive(STATE_FETCH_INST, OP_NOP, 1'b0);
    tick();
    checks++;
    if (strobes() !== W_NONE || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL halted_ignore: strobes=%b h=%b expected %b 1", strobes(), bus.halted, W_NONE);
    end
    drive(STATE_NEXT, OP_NOP, 1'b0);
    tick();
    checks++;
    if (bus.reset_cycle !== 1'b0) begin
      errors++;
      $display("FAIL halted_next: rc=%b expected 0", bus.reset_cycle);
    end
    drive(STATE_FETCH_PC, OP_NOP, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.reset_cycle !== 1'b0 || strobes() !== W_NONE) begin
        errors++;
        $display("FAIL halted_frozen%0d: rc=%b strobes=%b expected 0 %b", i, bus.reset_cycle, strobes(), W_NONE);
      end
    end
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    checks++;
    if (bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_cleared: h=%b expected 0", bus.halted);
    end
    drive(4'hF, OP_NOP, 1'b0);
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++;
    if (bus.illegal !== 1'b1 || bus.halted !== 1'b1 || strobes() !== W_NONE) begin
      errors++;
      $display("FAIL illegal_trap: il=%b h=%b strobes=%b expected 1 1 %b", bus.illegal, bus.halted, strobes(), W_NONE);
    end
    drive(STATE_NEXT, OP_NOP, 1'b0);
    tick();
    checks++;
    if (bus.reset_cycle !== 1'b0 || bus.illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: rc=%b il=%b expected 0 1", bus.reset_cycle, bus.illegal);
    end
`else
    checks++;
    if (bus.illegal !== 1'b0 || bus.halted !== 1'b0 || strobes() !== W_NONE) begin
      errors++;
      $display("FAIL illegal_notrap: il=%b h=%b strobes=%b expected 0 0 %b", bus.illegal, bus.halted, strobes(), W_NONE);
    end
    drive(STATE_NEXT, OP_NOP, 1'b0);
    tick();
    checks++;
    if (bus.reset_cycle !== 1'b1) begin
      errors++;
      $display("FAIL illegal_continue: rc=%b expected 1", bus.reset_cycle);
    end
`endif
    $display("undefined state 4'hF: il=%b h=%b", bus.illegal, bus.halted);
  endtask

  initial begin
    reset = 1'b1;
    drive(STATE_FETCH_PC, OP_NOP, 1'b0);
    #12;
    test_reset();
    test_fetch();
    test_decode_table();
    test_alu_jump();
    test_jnz_next();
    test_watchdog();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
